// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: generalised forwarding bus record
// and stall cause encoding used by the optional stall statistics.
package hazard_scoreboard_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int RW_DEF   = $clog2(NREG_DEF);

  // One forwarding bus at the default widths (successor of tran_t).
  typedef struct packed {
    logic              valid;
    logic [RW_DEF-1:0] dst;
    logic [XLEN_DEF-1:0] data;
    logic              ismem;
  } fwd_bus_t;

  typedef enum logic [1:0] {
    STALL_NONE,
    STALL_LOADUSE,
    STALL_LONG,
    STALL_SAT
  } stall_cause_e;

  // Single cause for a stalled cycle: load-use beats long beats saturation.
  function automatic stall_cause_e stall_cause(input logic stall, input logic ldu,
                                               input logic lwait, input logic sat);
    if (!stall) return STALL_NONE;
    if (ldu)    return STALL_LOADUSE;
    if (lwait)  return STALL_LONG;
    if (sat)    return STALL_SAT;
    return STALL_NONE;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/forwarding/commit bundle between the pipeline and the scoreboard.
// Optional stall counters appear when SCOREBOARD_STATS_EN is defined.
interface hazard_scoreboard_if #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NPORT  = 2,
  parameter int NSTAGE = 2
);
  import hazard_scoreboard_pkg::*;

  localparam int RW = $clog2(NREG);

  logic                    issue_valid;
  logic                    issue_ready;
  logic [NPORT*RW-1:0]     issue_rs;
  logic                    issue_wen;
  logic [RW-1:0]           issue_rd;
  logic                    issue_long;
  logic [NPORT*XLEN-1:0]   rf_data;
  logic [NPORT*XLEN-1:0]   op_data;
  logic [NSTAGE-1:0]       fwd_valid;
  logic [NSTAGE*RW-1:0]    fwd_dst;
  logic [NSTAGE*XLEN-1:0]  fwd_data;
  logic [NSTAGE-1:0]       fwd_ismem;
  logic                    wb_valid;
  logic [RW-1:0]           wb_rd;
  logic                    long_done;
  logic [RW-1:0]           long_rd;
  logic [XLEN-1:0]         long_data;
  logic                    flush;
  logic                    pending_any;
`ifdef SCOREBOARD_STATS_EN
  logic [63:0]             stat_loaduse;
  logic [63:0]             stat_long;
  logic [63:0]             stat_sat;
`endif

  modport master (
    output issue_valid, issue_rs, issue_wen, issue_rd, issue_long, rf_data,
           fwd_valid, fwd_dst, fwd_data, fwd_ismem, wb_valid, wb_rd,
           long_done, long_rd, long_data, flush,
`ifdef SCOREBOARD_STATS_EN
    input  stat_loaduse, stat_long, stat_sat,
`endif
    input  issue_ready, op_data, pending_any
  );

  modport slave (
    input  issue_valid, issue_rs, issue_wen, issue_rd, issue_long, rf_data,
           fwd_valid, fwd_dst, fwd_data, fwd_ismem, wb_valid, wb_rd,
           long_done, long_rd, long_data, flush,
`ifdef SCOREBOARD_STATS_EN
    output stat_loaduse, stat_long, stat_sat,
`endif
    output issue_ready, op_data, pending_any
  );

endinterface

// File: rtl/hazard_scoreboard_operand_bypass.sv
// One operand read port: picks the youngest matching forwarding bus, then a
// completing long-latency result, then the regfile value, and flags why the
// operand cannot be used this cycle.
module hazard_scoreboard_operand_bypass
  import hazard_scoreboard_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NSTAGE = 2,
  parameter int RW     = $clog2(NREG)
) (
  input  logic [RW-1:0]          rs,
  input  logic [XLEN-1:0]        rf_data,
  input  logic [NSTAGE-1:0]      fwd_valid,
  input  logic [NSTAGE*RW-1:0]   fwd_dst,
  input  logic [NSTAGE*XLEN-1:0] fwd_data,
  input  logic [NSTAGE-1:0]      fwd_ismem,
  input  logic                   long_done,
  input  logic [RW-1:0]          long_rd,
  input  logic [XLEN-1:0]        long_data,
  input  logic                   cnt_busy,
  input  logic                   lng_busy,
  output logic [XLEN-1:0]        op_data,
  output logic                   loaduse,
  output logic                   long_wait,
  output logic                   unresolved
);

  logic            fwd_hit;
  logic            fwd_mem;
  logic [XLEN-1:0] fwd_val;
  logic            long_hit;

  // Priority mux; the descending scan lets the lowest (youngest) stage win.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_mem = 1'b0;
    fwd_val = '0;
    for (int s = NSTAGE - 1; s >= 0; s--) begin
      if (fwd_valid[s] && (fwd_dst[s*RW +: RW] == rs) && (rs != '0)) begin
        fwd_hit = 1'b1;
        fwd_mem = fwd_ismem[s];
        fwd_val = fwd_data[s*XLEN +: XLEN];
      end
    end
    long_hit = long_done && (long_rd == rs) && (rs != '0);

    if (rs == '0)     op_data = '0;
    else if (fwd_hit) op_data = fwd_val;
    else if (long_hit) op_data = long_data;
    else              op_data = rf_data;

    loaduse    = fwd_hit && fwd_mem;
    long_wait  = lng_busy && !long_hit;
    unresolved = cnt_busy && !fwd_hit && !long_hit;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight writer table with operand bypass and issue stall.
// Optional feature macro: SCOREBOARD_STATS_EN (per-cause stall counters).
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NPORT  = 2,
  parameter int NSTAGE = 2,
  parameter int CNTW   = 2
) (
  input  logic          clk,
  input  logic          reset,
  hazard_scoreboard_if.slave bus
);

  localparam int RW = $clog2(NREG);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [CNTW-1:0]       cnt     [NREG];
  logic [CNTW-1:0]       cnt_nxt [NREG];
  logic [NREG-1:0]       lng;
  logic [NREG-1:0]       lng_nxt;

  logic [NPORT-1:0]      port_ldu;
  logic [NPORT-1:0]      port_lwait;
  logic [NPORT-1:0]      port_unres;
  logic [NPORT*XLEN-1:0] op_flat;

  logic                  waw;
  logic                  sat;
  logic                  issue_fire;

  logic                  inc_r;
  logic                  wb_r;
  logic                  ld_r;
  logic [CNTW:0]         up_r;
  logic [1:0]            dec_r;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [RW-1:0] rs;
    assign rs = bus.issue_rs[p*RW +: RW];

    hazard_scoreboard_operand_bypass #(
      .XLEN(XLEN), .NREG(NREG), .NSTAGE(NSTAGE), .RW(RW)
    ) u_bypass (
      .rs        (rs),
      .rf_data   (bus.rf_data[p*XLEN +: XLEN]),
      .fwd_valid (bus.fwd_valid),
      .fwd_dst   (bus.fwd_dst),
      .fwd_data  (bus.fwd_data),
      .fwd_ismem (bus.fwd_ismem),
      .long_done (bus.long_done),
      .long_rd   (bus.long_rd),
      .long_data (bus.long_data),
      .cnt_busy  (cnt[rs] != '0),
      .lng_busy  (lng[rs]),
      .op_data   (op_flat[p*XLEN +: XLEN]),
      .loaduse   (port_ldu[p]),
      .long_wait (port_lwait[p]),
      .unresolved(port_unres[p])
    );
  end

  assign bus.op_data = op_flat;

  assign waw = bus.issue_wen && lng[bus.issue_rd];
  assign sat = bus.issue_wen && (cnt[bus.issue_rd] == CNT_MAX);
  assign bus.issue_ready = !(|port_ldu) && !(|port_lwait) && !(|port_unres) && !waw && !sat;
  assign issue_fire = bus.issue_valid && bus.issue_ready && bus.issue_wen &&
                      (bus.issue_rd != '0);

  // Next table contents: net of issue/writeback/long-completion events, floored at zero.
  always_comb begin
    inc_r = 1'b0;
    wb_r  = 1'b0;
    ld_r  = 1'b0;
    up_r  = '0;
    dec_r = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = '0;
      lng_nxt[r] = 1'b0;
    end
    if (!bus.flush) begin
      for (int r = 1; r < NREG; r++) begin
        inc_r = issue_fire && (bus.issue_rd == RW'(r));
        wb_r  = bus.wb_valid && (bus.wb_rd == RW'(r));
        ld_r  = bus.long_done && (bus.long_rd == RW'(r));
        up_r  = {1'b0, cnt[r]} + (CNTW+1)'(inc_r);
        dec_r = {1'b0, wb_r} + {1'b0, ld_r};
        cnt_nxt[r] = (up_r > (CNTW+1)'(dec_r)) ? CNTW'(up_r - (CNTW+1)'(dec_r)) : '0;
        lng_nxt[r] = inc_r ? bus.issue_long : (ld_r ? 1'b0 : lng[r]);
      end
    end
  end

  // Table register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      lng <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      lng <= lng_nxt;
    end
  end

  // Any register with an outstanding writer.
  always_comb begin
    bus.pending_any = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (cnt[r] != '0) bus.pending_any = 1'b1;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  stall_cause_e cause;
  logic [63:0]  st_ldu;
  logic [63:0]  st_lng;
  logic [63:0]  st_sat;

  assign cause = stall_cause(bus.issue_valid && !bus.issue_ready, |port_ldu,
                             (|port_lwait) || waw, sat);

  // Stall counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_ldu <= '0;
      st_lng <= '0;
      st_sat <= '0;
    end else begin
      case (cause)
        STALL_LOADUSE: st_ldu <= st_ldu + 64'd1;
        STALL_LONG:    st_lng <= st_lng + 64'd1;
        STALL_SAT:     st_sat <= st_sat + 64'd1;
        default:       ;
      endcase
    end
  end

  assign bus.stat_loaduse = st_ldu;
  assign bus.stat_long    = st_lng;
  assign bus.stat_sat     = st_sat;
`endif

endmodule
